// File: rtl/vga_rect_filler_pkg.sv
// Shared screen geometry, coordinate widths and FSM encoding for the rectangle filler.
// Also holds the helper that turns an (origin, size) pair into a clipped inclusive end coordinate.
package vga_rect_filler_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   // One extra bit on the sum so origin+size never wraps before the clamp.
   function automatic logic [X_W-1:0] clip_end_x(input logic [X_W-1:0] org,
                                                 input logic [X_W-1:0] len);
      logic [X_W:0] sum;
      sum = {1'b0, org} + {1'b0, len};
      if (sum > (X_W+1)'(SCREEN_W))
         sum = (X_W+1)'(SCREEN_W);
      return X_W'(sum - (X_W+1)'(1));
   endfunction

   function automatic logic [Y_W-1:0] clip_end_y(input logic [Y_W-1:0] org,
                                                 input logic [Y_W-1:0] len);
      logic [Y_W:0] sum;
      sum = {1'b0, org} + {1'b0, len};
      if (sum > (Y_W+1)'(SCREEN_H))
         sum = (Y_W+1)'(SCREEN_H);
      return Y_W'(sum - (Y_W+1)'(1));
   endfunction

endpackage

// File: rtl/vga_rect_filler_if.sv
// Command handshake plus the pixel stream towards one VGA adapter channel.
// The filler sits on the slave side; the command source / adapter side uses master.
interface vga_rect_filler_if;
   import vga_rect_filler_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   logic [X_W-1:0]      cmd_x;
   logic [Y_W-1:0]      cmd_y;
   logic [X_W-1:0]      cmd_w;
   logic [Y_W-1:0]      cmd_h;
   logic [COLOUR_W-1:0] cmd_colour;
   logic                pause;
   logic [X_W-1:0]      x;
   logic [Y_W-1:0]      y;
   logic [COLOUR_W-1:0] colour;
   logic                plot;
   logic                busy;
   logic                done;

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour, pause,
      input  cmd_ready, x, y, colour, plot, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour, pause,
      output cmd_ready, x, y, colour, plot, busy, done
   );

endinterface

// File: rtl/vga_rect_filler_raster_counter.sv
// Raster-order x/y walker over an inclusive box; load sets origin and bounds, step advances.
// last_o flags the bottom-right corner so the owner can stop stepping there.
module vga_rect_filler_raster_counter
   import vga_rect_filler_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           load_i,
   input  logic           step_i,
   input  logic [X_W-1:0] x0_i,
   input  logic [Y_W-1:0] y0_i,
   input  logic [X_W-1:0] x_end_i,
   input  logic [Y_W-1:0] y_end_i,
   output logic [X_W-1:0] x_o,
   output logic [Y_W-1:0] y_o,
   output logic           last_o
);

   logic [X_W-1:0] x_q, x_d, x0_q, x0_d, x_end_q, x_end_d;
   logic [Y_W-1:0] y_q, y_d, y_end_q, y_end_d;

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      x0_d    = x0_q;
      x_end_d = x_end_q;
      y_end_d = y_end_q;
      if (load_i) begin
         x_d     = x0_i;
         y_d     = y0_i;
         x0_d    = x0_i;
         x_end_d = x_end_i;
         y_end_d = y_end_i;
      end else if (step_i) begin
         if (x_q == x_end_q) begin
            x_d = x0_q;
            y_d = y_q + Y_W'(1);
         end else begin
            x_d = x_q + X_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x_q     <= '0;
         y_q     <= '0;
         x0_q    <= '0;
         x_end_q <= '0;
         y_end_q <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         x0_q    <= x0_d;
         x_end_q <= x_end_d;
         y_end_q <= y_end_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = (x_q == x_end_q) && (y_q == y_end_q);

endmodule

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine: accepts one clipped fill command and streams its pixels in raster
// order, one per clock unless paused, then pulses done for a single cycle.
//
//   state   | meaning
//   IDLE    | cmd_ready high, waiting for cmd_valid
//   DRAW    | presenting pixels; plot high on every non-paused cycle
//   FIN     | one-cycle done pulse, busy low, back to IDLE next
module vga_rect_filler
   import vga_rect_filler_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   vga_rect_filler_if.slave   bus
);

   state_e              state_q, state_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic           accept;
   logic           empty;
   logic           cnt_load;
   logic           cnt_step;
   logic           cnt_last;
   logic [X_W-1:0] cnt_x;
   logic [Y_W-1:0] cnt_y;
   logic [X_W-1:0] x_end;
   logic [Y_W-1:0] y_end;

   assign accept = (state_q == ST_IDLE) && bus.cmd_valid;
   assign empty  = (bus.cmd_w == '0) || (bus.cmd_h == '0)
                || (bus.cmd_x >= X_W'(SCREEN_W)) || (bus.cmd_y >= Y_W'(SCREEN_H));
   assign x_end  = clip_end_x(bus.cmd_x, bus.cmd_w);
   assign y_end  = clip_end_y(bus.cmd_y, bus.cmd_h);

   always_comb begin
      state_d  = state_q;
      colour_d = colour_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_step = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               colour_d = bus.cmd_colour;
               if (empty) begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d  = ST_DRAW;
                  busy_d   = 1'b1;
                  cnt_load = 1'b1;
               end
            end
         end
         ST_DRAW: begin
            // A paused cycle neither plots nor advances, so the held pixel is emitted later.
            if (!bus.pause) begin
               if (cnt_last) begin
                  state_d = ST_FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  cnt_step = 1'b1;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         colour_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         colour_q <= colour_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   vga_rect_filler_raster_counter u_raster (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (cnt_load),
      .step_i  (cnt_step),
      .x0_i    (bus.cmd_x),
      .y0_i    (bus.cmd_y),
      .x_end_i (x_end),
      .y_end_i (y_end),
      .x_o     (cnt_x),
      .y_o     (cnt_y),
      .last_o  (cnt_last)
   );

   assign bus.cmd_ready = (state_q == ST_IDLE);
   assign bus.x         = cnt_x;
   assign bus.y         = cnt_y;
   assign bus.colour    = colour_q;
   assign bus.plot      = (state_q == ST_DRAW) && !bus.pause;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule
